// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package adder_sched_pkg;

    // FSM states; ST_LOCKED is only reachable when chaining is compiled in
    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_t;

    // Upper bound on requesters handled by rr_pick, and its index width
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = $clog2(RR_MAX);

    // One-hot grant: first valid bit scanning upward from ptr+1, wrapping modulo n
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       ptr,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] g;
        int unsigned       idx;
        g   = '0;
        idx = 0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            if (k <= n && g == '0) begin
                idx = (ptr + k) % n;
                if (valid[idx[RR_IDX_W-1:0]]) begin
                    g[idx[RR_IDX_W-1:0]] = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator: lowest-priority slot is the one just served (ptr).
// Latency: 0 cycles (combinational grant from valid/ptr).
// Backpressure: advance=0 suppresses every grant; the pointer itself lives in the caller.
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [RR_MAX-1:0] pick;

    // Pick the next valid requester after ptr and encode its index
    always_comb begin
        pick      = rr_pick(RR_MAX'(valid), int'(ptr), NUM_REQ);
        grant     = advance ? pick[NUM_REQ-1:0] : '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/test_adder.sv
// Combinational WIDTH-bit adder with carry in and carry out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is captured.
module test_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Add at WIDTH+1 bits so the top bit is the carry out
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_rr_scheduler.sv
// Time-shares one test_adder across NUM_REQ requesters with round-robin arbitration.
// Latency: 1 cycle from accepted request to registered response.
// Backpressure: a held response (rsp_valid & !rsp_ready) blocks all grants; ADDER_SCHED_CHAIN_EN adds multi-beat carry chaining.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    input  logic [NUM_REQ-1:0]       req_chain,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id
);

    logic               can_accept;
    logic [ID_W-1:0]    rr_ptr;
    logic               arb_adv;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic [NUM_REQ-1:0] sel_oh;
    logic [ID_W-1:0]    sel_idx;
    logic               sel_cin;
    logic               last_beat;
    logic               xfer;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // Accept a new request whenever the response slot is empty or drains this cycle
    assign can_accept = !rsp_valid | rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .advance   (arb_adv),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

`ifdef ADDER_SCHED_CHAIN_EN
    sched_state_t    state;
    logic [ID_W-1:0] lock_id;
    logic            carry_q;

    assign arb_adv   = (state == ST_ARB);
    assign last_beat = !req_chain[sel_idx];

    // While locked only the chain owner is selected and its carry comes from carry_q
    always_comb begin
        sel_oh  = arb_grant;
        sel_idx = arb_idx;
        sel_cin = req_cin[arb_idx];
        if (state == ST_LOCKED) begin
            sel_idx = lock_id;
            sel_cin = carry_q;
            for (int i = 0; i < NUM_REQ; i++) begin
                sel_oh[i] = (lock_id == ID_W'(i));
            end
        end
    end

    // Chain FSM: lock onto a requester for the beats of a multi-precision add
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_ARB;
            lock_id <= '0;
            carry_q <= 1'b0;
        end else if (xfer) begin
            case (state)
                ST_ARB: begin
                    if (req_chain[sel_idx]) begin
                        state   <= ST_LOCKED;
                        lock_id <= sel_idx;
                        carry_q <= add_cout;
                    end
                end
                ST_LOCKED: begin
                    carry_q <= add_cout;
                    if (!req_chain[sel_idx]) begin
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end
`else
    logic unused_chain;

    assign unused_chain = ^req_chain;
    assign arb_adv      = 1'b1;
    assign last_beat    = 1'b1;
    assign sel_oh       = arb_grant;
    assign sel_idx      = arb_idx;
    assign sel_cin      = req_cin[arb_idx];
`endif

    assign req_ready = sel_oh & {NUM_REQ{can_accept}};
    assign xfer      = |(req_valid & req_ready);
    assign op_a      = req_a[sel_idx*WIDTH +: WIDTH];
    assign op_b      = req_b[sel_idx*WIDTH +: WIDTH];

    test_adder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (sel_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Response register: load on transfer, drop valid once consumed, hold under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= sel_idx;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances once per completed turn (a whole chain counts as one)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (xfer && last_beat) begin
            rr_ptr <= sel_idx;
        end
    end

endmodule
